// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning blocks: FSM state encoding
// and default timing for a 100 MHz ck.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH      = 3'd1,
        ST_PRESS_DB  = 3'd2,
        ST_WAIT_HOLD = 3'd3,
        ST_REP_PUSH  = 3'd4,
        ST_REP_WAIT  = 3'd5,
        ST_REL_DB    = 3'd6
    } btn_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 100_000;     // 1 ms
    localparam int DEF_HOLD_CYCLES     = 50_000_000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES   = 10_000_000;  // 100 ms
    localparam int DEF_TIMER_W         = 27;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single raw asynchronous level; q is the last stage.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic ck,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_repeat_pulser.sv
// Push-button conditioner: synchronise, debounce, one push pulse per press,
// plus auto-repeat pulses while the button stays held.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | waiting for btn_s high
//   PUSH      | press accepted, push pulse requested
//   PRESS_DB  | press debounce, button ignored
//   WAIT_HOLD | held, counting towards the first repeat
//   REP_PUSH  | repeat pulse requested
//   REP_WAIT  | held in repeat mode, counting to next repeat
//   REL_DB    | release debounce, button ignored
module button_repeat_pulser
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int TIMER_W         = DEF_TIMER_W
) (
    input  logic ck,
    input  logic reset,
    input  logic button,
    output logic push,
    output logic held,
    output logic pressed
);

    localparam logic [TIMER_W-1:0] DB_LAST   = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REP_LAST  = TIMER_W'(REPEAT_CYCLES - 1);

    logic btn_s;

    btn_state_e         state_q,   state_d;
    logic [TIMER_W-1:0] timer_q,   timer_d;
    logic               push_q,    push_d;
    logic               held_q,    held_d;
    logic               pressed_q, pressed_d;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_btn_sync (
        .ck   (ck),
        .reset(reset),
        .d    (button),
        .q    (btn_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (btn_s) state_d = ST_PUSH;
            ST_PUSH:      state_d = ST_PRESS_DB;
            ST_PRESS_DB:  if (timer_q == DB_LAST) state_d = ST_WAIT_HOLD;
            ST_WAIT_HOLD: begin
                if (!btn_s)                    state_d = ST_REL_DB;
                else if (timer_q == HOLD_LAST) state_d = ST_REP_PUSH;
            end
            ST_REP_PUSH:  state_d = ST_REP_WAIT;
            ST_REP_WAIT: begin
                if (!btn_s)                   state_d = ST_REL_DB;
                else if (timer_q == REP_LAST) state_d = ST_REP_PUSH;
            end
            ST_REL_DB:    if (timer_q == DB_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        timer_d = (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);

        // Outputs are registered decodes of the current state, adding one
        // cycle of latency and keeping button off any output path.
        push_d    = (state_q == ST_PUSH) || (state_q == ST_REP_PUSH);
        held_d    = (state_q == ST_REP_PUSH) || (state_q == ST_REP_WAIT);
        pressed_d = (state_q == ST_PUSH) || (state_q == ST_PRESS_DB) ||
                    (state_q == ST_WAIT_HOLD) || held_d;
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            push_q    <= 1'b0;
            held_q    <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            push_q    <= push_d;
            held_q    <= held_d;
            pressed_q <= pressed_d;
        end
    end

    assign push    = push_q;
    assign held    = held_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_button_repeat_pulser.sv
// Directed bench for button_repeat_pulser: expected push edge numbers are queued
// per scenario and consumed as pulses appear; levels are checked at fixed edges.
module tb_button_repeat_pulser;

    logic ck = 1'b0;
    logic reset = 1'b1;
    logic button = 1'b0;
    logic push, held, pressed;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int e0;
    int exp_q[$];

    button_repeat_pulser #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .TIMER_W        (27)
    ) dut (
        .ck     (ck),
        .reset  (reset),
        .button (button),
        .push   (push),
        .held   (held),
        .pressed(pressed)
    );

    always #5 ck = ~ck;

    // One clock edge; any push seen afterwards must match the head of the queue.
    task automatic step();
        int exp_t;
        @(posedge ck);
        #1;
        edge_n++;
        if (push === 1'b1) begin
            exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            total++;
            assert (edge_n === exp_t) else begin
                bad++;
                $error("FAIL push_time obs_edge=%0d exp_edge=%0d", edge_n, exp_t);
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_drained(input string tag);
        total++;
        assert (exp_q.size() === 0) else begin
            bad++;
            $error("FAIL %s pending_pulses obs=%0d exp=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // 1: reset with a toggling button, then quiet
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            button = i[0];
            step();
            chk("s1_rst_push", push, 1'b0);
            chk("s1_rst_held", held, 1'b0);
            chk("s1_rst_pressed", pressed, 1'b0);
        end
        reset = 1'b0;
        button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s1_idle_push", push, 1'b0);
            chk("s1_idle_pressed", pressed, 1'b0);
        end
        chk_drained("s1_drained");

        // 2: clean press of 12 cycles
        e0 = edge_n + 1;
        exp_q.push_back(e0 + 3);
        for (int i = 0; i <= 22; i++) begin
            button = (i < 12);
            step();
            if (i == 2)  chk("s2_pressed_before", pressed, 1'b0);
            if (i == 3)  chk("s2_pressed_at_p", pressed, 1'b1);
            if (i == 14) chk("s2_pressed_hold", pressed, 1'b1);
            if (i == 15) chk("s2_pressed_rel", pressed, 1'b0);
            if (i == 20) chk("s2_held_idle", held, 1'b0);
        end
        chk_drained("s2_drained");

        // 3: bouncy press and bouncy release
        e0 = edge_n + 1;
        exp_q.push_back(e0 + 3);
        for (int i = 0; i <= 34; i++) begin
            if (i < 5)       button = ~i[0];
            else if (i < 15) button = 1'b1;
            else             button = (i == 16) || (i == 18);
            step();
            if (i == 10) chk("s3_pressed_mid", pressed, 1'b1);
            if (i == 30) chk("s3_pressed_end", pressed, 1'b0);
        end
        chk_drained("s3_drained");

        // 4: long hold, 60 cycles
        e0 = edge_n + 1;
        exp_q.push_back(e0 + 3);
        exp_q.push_back(e0 + 28);
        exp_q.push_back(e0 + 37);
        exp_q.push_back(e0 + 46);
        exp_q.push_back(e0 + 55);
        for (int i = 0; i <= 85; i++) begin
            button = (i < 60);
            step();
            if (i == 27) chk("s4_held_before", held, 1'b0);
            if (i == 28) chk("s4_held_rise", held, 1'b1);
            if (i == 50) chk("s4_held_mid", held, 1'b1);
            if (i == 62) chk("s4_held_last", held, 1'b1);
            if (i == 63) chk("s4_held_fall", held, 1'b0);
            if (i == 80) chk("s4_pressed_end", pressed, 1'b0);
        end
        chk_drained("s4_drained");

        // 5: one-cycle reset during repeat mode, button still held
        e0 = edge_n + 1;
        exp_q.push_back(e0 + 3);
        exp_q.push_back(e0 + 28);
        exp_q.push_back(e0 + 37);   // new press: 3 edges after first non-reset edge
        for (int i = 0; i <= 65; i++) begin
            button = (i < 45);
            reset = (i == 33);
            step();
            if (i == 32) chk("s5_held_pre", held, 1'b1);
            if (i == 33) begin
                chk("s5_rst_push", push, 1'b0);
                chk("s5_rst_held", held, 1'b0);
                chk("s5_rst_pressed", pressed, 1'b0);
            end
            if (i == 37) chk("s5_pressed_new", pressed, 1'b1);
            if (i == 40) chk("s5_held_after", held, 1'b0);
        end
        reset = 1'b0;
        chk_drained("s5_drained");

        // 6: two-cycle release glitch during hold wait
        e0 = edge_n + 1;
        exp_q.push_back(e0 + 3);
        exp_q.push_back(e0 + 21);
        for (int i = 0; i <= 50; i++) begin
            button = (i < 30) && (i != 13) && (i != 14);
            step();
            if (i == 15) chk("s6_pressed_pre_rel", pressed, 1'b1);
            if (i == 16) chk("s6_pressed_rel", pressed, 1'b0);
            if (i == 21) chk("s6_pressed_repress", pressed, 1'b1);
            if (i == 45) chk("s6_pressed_end", pressed, 1'b0);
        end
        chk_drained("s6_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
